// File: rtl/memory_stage.sv
// Memory-access stage: data RAM, stack pointer, loads/stores/push/pop and jump resolution.
// Optional stack bounds checking is enabled by defining MEM_STACK_GUARD_EN.
module memory_stage #(
    parameter int unsigned        DATA_W     = 16,
    parameter int unsigned        ADDR_W     = 8,
    parameter logic [ADDR_W-1:0]  STACK_BASE = 8'hFF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [3:0]        c_addr_in,
    input  logic              reg_write_in,
    input  logic              data_read_in,
    input  logic              data_write_in,
    input  logic              stack_command_in,
    input  logic [1:0]        stack_ctl_in,
    input  logic [1:0]        j_ctl_in,
    input  logic [1:0]        alu_flags_in,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        wb_c_addr,
    output logic              wb_reg_write,
    output logic              wb_valid,
    output logic              jump_taken,
    output logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] stack_pointer,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    typedef enum logic [0:0] {StIdle, StRdData} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_q;
    logic              pop_supp_q;
    logic              ovf_q, unf_q;

    logic              is_push, is_pop, is_load, is_store, needs_read;
    logic              push_block, pop_block, jump_cond;
    logic              mem_we, rd_en, complete, ovf_set, unf_set;
    logic [ADDR_W-1:0] mem_waddr, rd_addr;

    // Stack op outranks load, which outranks store.
    assign is_push    = stack_command_in && (stack_ctl_in == 2'b01);
    assign is_pop     = stack_command_in && (stack_ctl_in == 2'b10);
    assign is_load    = !(is_push || is_pop) && data_read_in;
    assign is_store   = !(is_push || is_pop) && !data_read_in && data_write_in;
    assign needs_read = valid_in && (is_pop || is_load);

`ifdef MEM_STACK_GUARD_EN
    assign push_block = (sp_q == '0);
    assign pop_block  = (sp_q == STACK_BASE);
`else
    assign push_block = 1'b0;
    assign pop_block  = 1'b0;
`endif

    always_comb begin
        jump_cond = 1'b0;
        unique case (j_ctl_in)
            2'b00: jump_cond = 1'b0;
            2'b01: jump_cond = 1'b1;
            2'b10: jump_cond = alu_flags_in[0];
            2'b11: jump_cond = alu_flags_in[1];
            default: jump_cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        stall     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_in;
        rd_en     = 1'b0;
        rd_addr   = addr_in;
        complete  = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (needs_read) begin
                    stall   = 1'b1;
                    rd_en   = 1'b1;
                    state_d = StRdData;
                    if (is_pop) begin
                        rd_addr = sp_q + 1'b1;
                        if (pop_block) unf_set = 1'b1;
                        else           sp_d    = sp_q + 1'b1;
                    end
                end else begin
                    complete = 1'b1;
                    if (valid_in && is_push) begin
                        if (push_block) begin
                            ovf_set = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = sp_q;
                            sp_d      = sp_q - 1'b1;
                        end
                    end else if (valid_in && is_store) begin
                        mem_we = 1'b1;
                    end
                end
            end
            StRdData: begin
                complete = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_waddr] <= result_in;
    end

    always_ff @(posedge CLK) begin
        if (rd_en) rd_q <= mem[rd_addr];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            sp_q         <= STACK_BASE;
            pop_supp_q   <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            wb_data      <= '0;
            wb_c_addr    <= '0;
            wb_reg_write <= 1'b0;
            wb_valid     <= 1'b0;
            jump_taken   <= 1'b0;
            jump_target  <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_q | ovf_set;
            unf_q   <= unf_q | unf_set;
            if (rd_en) pop_supp_q <= unf_set;
            // Upstream still presents the read instruction in RD_DATA, so inputs are reused.
            if (complete) begin
                wb_valid     <= valid_in;
                wb_c_addr    <= c_addr_in;
                jump_taken   <= valid_in && jump_cond;
                jump_target  <= addr_in;
                if (state_q == StRdData) begin
                    wb_data      <= pop_supp_q ? '0 : rd_q;
                    wb_reg_write <= reg_write_in && !pop_supp_q;
                end else begin
                    wb_data      <= result_in;
                    wb_reg_write <= reg_write_in;
                end
            end
        end
    end

    assign stack_pointer   = sp_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule
